dip_sobel_stream: RTL and testbench
===================================

Name: dip_sobel_stream

Overview:
- Parametrised next-generation Sobel edge engine for the camera-to-SDRAM path.
- Accepts a raster grey pixel stream, builds the 3x3 window internally and computes |Gx|+|Gy|.
- Emits exactly one RGB565 word per input pixel, with runtime mode/threshold, border zeroing and an automatic end-of-frame flush.
- Sits between the greyscale converter and the SDRAM write FIFO; produces a write-enable/data pair.

Parameters:
IMG_W, 1024, active pixels per line (>=4)
IMG_H, 768, lines per frame (>=3)
DW, 8, grey pixel width (6..12)
THR_RST, 12, cfg threshold latched when cfg_thr is sampled as 0 after reset (0 disables override)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  pixel beat qualifier; no backpressure
in_sof  in  1  start of frame, coincident with first pixel beat
in_data  in  DW  grey pixel
cfg_mode  in  2  0 binary, 1 magnitude, 2 |Gx| only, 3 |Gy| only
cfg_thr  in  DW+3  edge threshold (binary mode)
cfg_inv  in  1  invert binary output
out_valid  out  1  SDRAM write enable
out_data  out  16  RGB565 pixel
out_sof  out  1  with first output of frame
out_eof  out  1  with last output of frame
frame_err  out  1  one-cycle pulse on truncated frame

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, counters 0; line-buffer contents don't-care.
- FSM states: IDLE, FILL, RUN, FLUSH.
  - IDLE -> FILL on in_valid&in_sof. Beats without sof in IDLE are ignored.
  - FILL: the first IMG_W+1 beats produce no output. Then -> RUN.
  - RUN: input beat k (k >= IMG_W+1) triggers output of pixel k-(IMG_W+1).
  - RUN -> FLUSH after beat IMG_W*IMG_H-1.
  - FLUSH: generates IMG_W+1 internal beats on consecutive clocks, zero data, no input needed. Then -> IDLE.
- Latency: out_valid rises exactly 3 clk after the triggering beat (internal or external). Stages:
  - S1: window register
  - S2: Gx, Gy as signed DW+3 bits
  - S3: abs, sum saturated to DW+3 bits, format, output register
- Total outputs per frame = IMG_W*IMG_H. out_sof is on output 0; out_eof is on output IMG_W*IMG_H-1.
- Border: pixels in row 0, row IMG_H-1, col 0 or col IMG_W-1 force magnitude 0. Binary mode with cfg_inv still inverts these.
- Gx = (p13+2p23+p33)-(p11+2p21+p31); Gy = (p31+2p32+p33)-(p11+2p12+p13).
- Mode magnitude: mag = |Gx|+|Gy|.
- Modes 2/3: mag = |Gx| or |Gy| respectively.
- Binary (mode 0): edge = (|Gx|+|Gy|) > cfg_thr. Output 16'hFFFF if edge^cfg_inv, else 16'h0000.
- Magnitude modes: g = min(mag, 2^DW-1). out_data = {g[DW-1:DW-5], g[DW-1:DW-6], g[DW-1:DW-5]}.
- cfg_mode, cfg_thr and cfg_inv are sampled on the sof beat and held constant for the frame. If cfg_thr==0 at sample, THR_RST is used.
- in_sof during FILL/RUN/FLUSH (abort):
  - frame_err pulses 1 clk later.
  - Pipeline valids are cleared and no out_eof is issued for the old frame.
  - The new frame starts in FILL with that beat as pixel 0.
- in_valid without sof during FLUSH is ignored. The flush has priority; each such beat also raises frame_err.
- Line/column counters wrap at IMG_W-1 / IMG_H-1. The column index of each output pixel is tracked through the pipeline to apply border zeroing.

Decomposition:
- Package dip_sobel_pkg holds:
  - mode constants (MODE_BIN, MODE_MAG, MODE_GX, MODE_GY)
  - FSM state encoding
  - function sat_u(width)
  - localparam MAG_W = DW+3
- Sub-module dip_win3x3_lb: two IMG_W-deep DW-bit line buffers (inferred RAM) plus 3x3 register window.
  - Advances only on a beat (external or flush).
  - Provides p11..p33 and a registered beat-valid.

Test Plan (IMG_W=8, IMG_H=6, DW=8 unless stated):
1. Flat frame of 50, mode 0, thr 12 -> 48 outputs, all 16'h0000; out_sof on first, out_eof on 48th.
2. Cols 0-3 = 0, cols 4-7 = 200, mode 0 -> rows 1-4 cols 3,4 = 16'hFFFF, rest 0. Mode 3 -> all 16'h0000. Mode 2 -> cols 3,4 = 16'hFFFF (800 saturated).
3. Single pixel 100 at (2,2), mode 1 -> (2,1),(2,3),(1,2),(3,2) = 16'hCE59 (mag 200); diagonals (1,1) etc. = 16'hCE59; (2,2) = 16'h0000.
4. Flush: after last input beat, no further inputs -> exactly 9 more outputs on consecutive clocks, 3 clk pipeline offset, last carries out_eof; FSM back in IDLE.
5. Abort: in_sof after 20 beats -> frame_err pulse; no out_eof for frame A; next full frame yields exactly 48 outputs with correct out_sof.
6. rst asserted mid-FLUSH -> out_valid/out_data/out_sof/out_eof all 0 while rst high. Next frame after release behaves as scenario 1.

Source files
------------

// File: rtl/dip_sobel_pkg.sv
// Shared definitions for the Sobel edge stream engine.
//   - output mode encodings
//   - FSM state encoding (also exported on the debug state port)
//   - sat_u: unsigned saturation helper
//   - MAG_W: gradient/magnitude width for the default 8-bit pixel build
package dip_sobel_pkg;

  localparam logic [1:0] MODE_BIN = 2'd0;
  localparam logic [1:0] MODE_MAG = 2'd1;
  localparam logic [1:0] MODE_GX  = 2'd2;
  localparam logic [1:0] MODE_GY  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } dip_state_e;

  localparam int SOBEL_DW = 8;
  localparam int MAG_W    = SOBEL_DW + 3;

  // Clamp v to the largest value representable in 'width' unsigned bits.
  function automatic logic [31:0] sat_u(input logic [31:0] v, input int width);
    logic [31:0] lim;
    lim = (32'd1 << width) - 32'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/dip_win3x3_lb.sv
// 3x3 sliding window over a raster pixel stream.
// Ports:
//   clk, rst          clock, async active-high reset
//   beat_i            advance the window by one pixel
//   restart_i         this beat is column 0 of a new frame
//   data_i            pixel entering at bottom-right (p33)
//   win_vld_o         registered copy of beat_i (window just advanced)
//   p11_o..p33_o      window, row 1 = two lines up, column 3 = newest
module dip_win3x3_lb #(
  parameter int IMG_W = 1024,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          beat_i,
  input  logic          restart_i,
  input  logic [DW-1:0] data_i,
  output logic          win_vld_o,
  output logic [DW-1:0] p11_o,
  output logic [DW-1:0] p12_o,
  output logic [DW-1:0] p13_o,
  output logic [DW-1:0] p21_o,
  output logic [DW-1:0] p22_o,
  output logic [DW-1:0] p23_o,
  output logic [DW-1:0] p31_o,
  output logic [DW-1:0] p32_o,
  output logic [DW-1:0] p33_o
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [DW-1:0] lb1_q [IMG_W];  // previous line
  logic [DW-1:0] lb2_q [IMG_W];  // line before that
  logic [AW-1:0] col_q, col_d, addr;

  always_comb begin
    addr  = restart_i ? '0 : col_q;
    col_d = (addr == AW'(IMG_W - 1)) ? '0 : addr + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      win_vld_o <= 1'b0;
    end else begin
      win_vld_o <= beat_i;
      if (beat_i) col_q <= col_d;
    end
  end

  // Line buffers are read asynchronously at the current column so the
  // window advances in the same edge that writes the new pixel.
  always_ff @(posedge clk) begin
    if (beat_i) begin
      lb1_q[addr] <= data_i;
      lb2_q[addr] <= lb1_q[addr];
      p11_o <= p12_o;  p12_o <= p13_o;  p13_o <= lb2_q[addr];
      p21_o <= p22_o;  p22_o <= p23_o;  p23_o <= lb1_q[addr];
      p31_o <= p32_o;  p32_o <= p33_o;  p33_o <= data_i;
    end
  end

endmodule

// File: rtl/dip_sobel_stream.sv
// Sobel edge engine: raster grey stream in, one RGB565 word per pixel out.
// Ports:
//   clk, rst             clock, async active-high reset
//   in_valid/in_sof/in_data  pixel beats (no backpressure), sof on pixel 0
//   cfg_mode/cfg_thr/cfg_inv output mode, binary threshold, binary invert
//   out_valid/out_data   SDRAM write enable / RGB565 word
//   out_sof/out_eof      first / last output of a frame
//   frame_err            one-cycle pulse on abort or ignored flush beat
//   dbg_state_o          current FSM state
// Handshake: in_valid qualifies one pixel per clock with no ready; out_valid
// qualifies one output per clock and the consumer must always accept it.
// Output of the pixel centred one line and one column behind beat k appears
// three clocks after beat k; the last IMG_W+1 outputs are produced by
// internally generated zero beats after the final input pixel.
module dip_sobel_stream
  import dip_sobel_pkg::*;
#(
  parameter int IMG_W   = 1024,
  parameter int IMG_H   = 768,
  parameter int DW      = 8,
  parameter int THR_RST = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_data,
  input  logic [1:0]    cfg_mode,
  input  logic [DW+2:0] cfg_thr,
  input  logic          cfg_inv,
  output logic          out_valid,
  output logic [15:0]   out_data,
  output logic          out_sof,
  output logic          out_eof,
  output logic          frame_err,
  output dip_state_e    dbg_state_o
);

  localparam int MW     = DW + 3;
  localparam int N_PIX  = IMG_W * IMG_H;
  localparam int N_LAST = N_PIX + IMG_W;       // index of the final flush beat
  localparam int CW     = $clog2(N_LAST + 1);
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);

  dip_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;                 // beat index within frame
  logic [XW-1:0] col_q;                        // centre of next output
  logic [YW-1:0] row_q;
  logic [1:0]    mode_q;
  logic          inv_q;
  logic [MW-1:0] thr_q;

  logic sof_beat, abort, beat, emit, flush_data, ign_err;

  assign dbg_state_o = state_q;

  // ---------------- control FSM ----------------
  always_comb begin
    sof_beat   = in_valid & in_sof;
    abort      = sof_beat & (state_q != ST_IDLE);
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat       = 1'b0;
    emit       = 1'b0;
    flush_data = 1'b0;
    ign_err    = 1'b0;
    case (state_q)
      ST_FILL: if (in_valid) begin
        beat  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(IMG_W)) state_d = ST_RUN;
      end
      ST_RUN: if (in_valid) begin
        beat  = 1'b1;
        emit  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N_PIX - 1)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        beat       = 1'b1;
        emit       = 1'b1;
        flush_data = 1'b1;
        ign_err    = in_valid;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(N_LAST)) state_d = ST_IDLE;
      end
      default: ;
    endcase
    // A start of frame in any state restarts at pixel 0 and wins over flush.
    if (sof_beat) begin
      beat       = 1'b1;
      emit       = 1'b0;
      flush_data = 1'b0;
      ign_err    = 1'b0;
      cnt_d      = CW'(1);
      state_d    = ST_FILL;
    end
  end

  // ---------------- window ----------------
  logic          win_vld;
  logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

  dip_win3x3_lb #(.IMG_W(IMG_W), .DW(DW)) u_win (
    .clk       (clk),
    .rst       (rst),
    .beat_i    (beat),
    .restart_i (sof_beat),
    .data_i    (flush_data ? '0 : in_data),
    .win_vld_o (win_vld),
    .p11_o (p11), .p12_o (p12), .p13_o (p13),
    .p21_o (p21), .p22_o (p22), .p23_o (p23),
    .p31_o (p31), .p32_o (p32), .p33_o (p33)
  );

  // ---------------- S1 side info, captured with the window ----------------
  logic          s1_emit_q, s1_border_q, s1_sof_q, s1_eof_q, s1_inv_q;
  logic [1:0]    s1_mode_q;
  logic [MW-1:0] s1_thr_q;
  logic          s1_vld;

  assign s1_vld = win_vld & s1_emit_q;

  // ---------------- S2: gradients (two's complement in MW bits) ----------------
  logic [MW-1:0] gx_pos, gx_neg, gy_pos, gy_neg, gx_d, gy_d;

  always_comb begin
    gx_pos = MW'(p13) + (MW'(p23) << 1) + MW'(p33);
    gx_neg = MW'(p11) + (MW'(p21) << 1) + MW'(p31);
    gy_pos = MW'(p31) + (MW'(p32) << 1) + MW'(p33);
    gy_neg = MW'(p11) + (MW'(p12) << 1) + MW'(p13);
    gx_d   = gx_pos - gx_neg;
    gy_d   = gy_pos - gy_neg;
  end

  logic          s2_vld_q, s2_border_q, s2_sof_q, s2_eof_q, s2_inv_q;
  logic [1:0]    s2_mode_q;
  logic [MW-1:0] s2_thr_q, s2_gx_q, s2_gy_q;

  // ---------------- S3: magnitude, format ----------------
  logic [MW-1:0] ax, ay, sum, mag;
  logic [DW-1:0] g;
  logic          edge_hit;
  logic [15:0]   out_data_d;

  always_comb begin
    ax       = s2_gx_q[MW-1] ? (~s2_gx_q + MW'(1)) : s2_gx_q;
    ay       = s2_gy_q[MW-1] ? (~s2_gy_q + MW'(1)) : s2_gy_q;
    sum      = MW'(sat_u(32'(ax) + 32'(ay), MW));
    case (s2_mode_q)
      MODE_GX: mag = ax;
      MODE_GY: mag = ay;
      default: mag = sum;
    endcase
    if (s2_border_q) mag = '0;
    g        = DW'(sat_u(32'(mag), DW));
    // Border pixels are never edges, so inversion turns them white.
    edge_hit = ~s2_border_q & (sum > s2_thr_q);
    if (s2_mode_q == MODE_BIN)
      out_data_d = (edge_hit ^ s2_inv_q) ? 16'hFFFF : 16'h0000;
    else
      out_data_d = {g[DW-1 -: 5], g[DW-1 -: 6], g[DW-1 -: 5]};
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= MODE_BIN;
      inv_q       <= 1'b0;
      thr_q       <= '0;
      s1_emit_q   <= 1'b0;
      s1_border_q <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      s1_inv_q    <= 1'b0;
      s1_mode_q   <= MODE_BIN;
      s1_thr_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_border_q <= 1'b0;
      s2_sof_q    <= 1'b0;
      s2_eof_q    <= 1'b0;
      s2_inv_q    <= 1'b0;
      s2_mode_q   <= MODE_BIN;
      s2_thr_q    <= '0;
      s2_gx_q     <= '0;
      s2_gy_q     <= '0;
      out_valid   <= 1'b0;
      out_data    <= 16'h0000;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (sof_beat) begin
        mode_q <= cfg_mode;
        inv_q  <= cfg_inv;
        thr_q  <= (cfg_thr == '0) ? MW'(THR_RST) : cfg_thr;
        col_q  <= '0;
        row_q  <= '0;
      end else if (emit) begin
        if (col_q == XW'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= (row_q == YW'(IMG_H - 1)) ? '0 : row_q + YW'(1);
        end else begin
          col_q <= col_q + XW'(1);
        end
      end

      // Flush beats of the old frame still carry its configuration.
      s1_emit_q   <= emit;
      s1_border_q <= (row_q == '0) || (row_q == YW'(IMG_H - 1)) ||
                     (col_q == '0) || (col_q == XW'(IMG_W - 1));
      s1_sof_q    <= (row_q == '0) && (col_q == '0);
      s1_eof_q    <= (row_q == YW'(IMG_H - 1)) && (col_q == XW'(IMG_W - 1));
      s1_mode_q   <= mode_q;
      s1_inv_q    <= inv_q;
      s1_thr_q    <= thr_q;

      s2_vld_q    <= s1_vld & ~abort;
      s2_border_q <= s1_border_q;
      s2_sof_q    <= s1_sof_q;
      s2_eof_q    <= s1_eof_q;
      s2_mode_q   <= s1_mode_q;
      s2_inv_q    <= s1_inv_q;
      s2_thr_q    <= s1_thr_q;
      s2_gx_q     <= gx_d;
      s2_gy_q     <= gy_d;

      out_valid   <= s2_vld_q & ~abort;
      out_sof     <= s2_vld_q & ~abort & s2_sof_q;
      out_eof     <= s2_vld_q & ~abort & s2_eof_q;
      out_data    <= (s2_vld_q & ~abort) ? out_data_d : 16'h0000;
      frame_err   <= abort | ign_err;
    end
  end

endmodule

// File: tb/tb_dip_sobel_stream.sv
module tb_dip_sobel_stream;
  import dip_sobel_pkg::*;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;
  localparam int N  = W * H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid, in_sof, cfg_inv;
  logic [DW-1:0] in_data;
  logic [1:0]    cfg_mode;
  logic [DW+2:0] cfg_thr;
  logic          out_valid, out_sof, out_eof, frame_err;
  logic [15:0]   out_data;
  dip_state_e    dbg_state;

  dip_sobel_stream #(.IMG_W(W), .IMG_H(H), .DW(DW), .THR_RST(12)) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_sof (in_sof), .in_data (in_data),
    .cfg_mode (cfg_mode), .cfg_thr (cfg_thr), .cfg_inv (cfg_inv),
    .out_valid (out_valid), .out_data (out_data),
    .out_sof (out_sof), .out_eof (out_eof), .frame_err (frame_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [17:0]   exp_q[$];          // {sof, eof, data}
  logic [DW-1:0] img [N];
  logic [15:0]   exp_img [N];
  int  errors = 0;
  int  checks = 0;
  bit  sb_en = 1'b1;
  int  mon_cnt = 0, eof_cnt = 0, eof_cyc = -1, eof_seen = 0, err_pulses = 0;
  int  out_idx = 0;
  int  sof_edge = 0;
  logic [17:0] got_w, exp_w;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (sb_en && out_valid) begin
      got_w = {out_sof, out_eof, out_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output idx=%0d got %h exp none", out_idx, got_w);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_w !== exp_w) begin
          errors++;
          $display("FAIL out_word idx=%0d got %h exp %h", out_idx, got_w, exp_w);
        end
      end
      out_idx++;
      if (out_sof) mon_cnt = 1; else mon_cnt++;
      if (out_eof) begin
        eof_cyc = cyc;
        eof_cnt = mon_cnt;
        eof_seen++;
      end
    end
    if (frame_err) err_pulses++;
  end

  // ---------------- stimulus images and hand-computed results ----------------
  task automatic img_flat(input logic [DW-1:0] v);
    for (int i = 0; i < N; i++) img[i] = v;
  endtask

  task automatic img_step();
    for (int i = 0; i < N; i++) img[i] = ((i % W) < 4) ? 8'd0 : 8'd200;
  endtask

  task automatic img_point();
    for (int i = 0; i < N; i++) img[i] = 8'd0;
    img[2*W + 2] = 8'd100;
  endtask

  task automatic exp_fill(input logic [15:0] v);
    for (int i = 0; i < N; i++) exp_img[i] = v;
  endtask

  // Interior rows 1..4 at columns 3 and 4 see the step edge.
  task automatic exp_cols34(input logic [15:0] v);
    exp_fill(16'h0000);
    for (int r = 1; r <= 4; r++) begin
      exp_img[r*W + 3] = v;
      exp_img[r*W + 4] = v;
    end
  endtask

  // All 8 neighbours of the point at (2,2) have |Gx|+|Gy| = 200 -> 16'hCE59.
  task automatic exp_point();
    exp_fill(16'h0000);
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (dr != 0 || dc != 0) exp_img[(2+dr)*W + (2+dc)] = 16'hCE59;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_beats(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_data  = img[i];
      if (i == 0) sof_edge = cyc + 1;
    end
  endtask

  task automatic run_frame(input logic [1:0] mode, input logic [10:0] thr,
                           input logic inv, input bit poke);
    cfg_mode = mode;
    cfg_thr  = thr;
    cfg_inv  = inv;
    for (int i = 0; i < N; i++) exp_q.push_back({(i == 0), (i == N-1), exp_img[i]});
    eof_cyc = -1;
    drive_beats(N);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (poke) begin
      // A stray beat during flush is ignored but flagged.
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      chk("flush_beat_err", frame_err, 1);
    end
    repeat (16) @(negedge clk);
    // sof beat index 0; last flush beat index N+W; plus pipeline offset 2 edges
    chk("eof_timing", eof_cyc, sof_edge + N + W + 2);
    chk("frame_len", eof_cnt, N);
    chk("idle_after_flush", dbg_state, ST_IDLE);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  int e0, f0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    cfg_mode = 2'd0; cfg_thr = '0; cfg_inv = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_eof", out_eof, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Flat frame, binary: no edges anywhere; stray flush beat flagged.
    img_flat(8'd50); exp_fill(16'h0000);
    e0 = err_pulses;
    run_frame(2'd0, 11'd12, 1'b0, 1'b1);
    chk("flush_beat_err_count", err_pulses - e0, 1);

    // Vertical step edge in several modes and thresholds.
    img_step();
    exp_cols34(16'hFFFF); run_frame(2'd0, 11'd12,  1'b0, 1'b0);
    exp_fill(16'h0000);   run_frame(2'd3, 11'd12,  1'b0, 1'b0);
    exp_cols34(16'hFFFF); run_frame(2'd2, 11'd12,  1'b0, 1'b0);
    exp_cols34(16'hFFFF); run_frame(2'd0, 11'd0,   1'b0, 1'b0);  // default threshold
    exp_fill(16'h0000);   run_frame(2'd0, 11'd800, 1'b0, 1'b0);  // 800 > 800 is false
    exp_cols34(16'hFFFF); run_frame(2'd0, 11'd799, 1'b0, 1'b0);

    // Single bright pixel, magnitude mode.
    img_point(); exp_point();
    run_frame(2'd1, 11'd12, 1'b0, 1'b0);

    // Inverted binary on a flat frame: everything, borders included, is white.
    img_flat(8'd50); exp_fill(16'hFFFF);
    run_frame(2'd0, 11'd12, 1'b1, 1'b0);

    // Abort after 20 beats: only outputs already at the port survive (pixels 0..8).
    img_flat(8'd50); exp_fill(16'h0000);
    cfg_mode = 2'd0; cfg_thr = 11'd12; cfg_inv = 1'b0;
    for (int i = 0; i < 9; i++) exp_q.push_back({(i == 0), 1'b0, 16'h0000});
    e0 = err_pulses;
    f0 = eof_seen;
    drive_beats(20);
    run_frame(2'd0, 11'd12, 1'b0, 1'b0);
    chk("abort_err_count", err_pulses - e0, 1);
    chk("abort_eof_count", eof_seen - f0, 1);

    // Reset in the middle of a flush.
    sb_en = 1'b0;
    drive_beats(N);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_sof", out_sof, 0);
      chk("midrst_out_eof", out_eof, 0);
      chk("midrst_state", dbg_state, ST_IDLE);
    end
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    sb_en = 1'b1;
    img_flat(8'd50); exp_fill(16'h0000);
    run_frame(2'd0, 11'd12, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
